// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU control path: opcodes, control steps
// and the instruction classes the sequencer branches on.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] DEFAULT_ADD_OP = 5'b00011;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_REG, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_BR, CLS_NOP, CLS_HALT
  } op_class_e;

  // Unlisted opcodes fall through to nop.
  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: classify = CLS_REG;
      OP_ADDI, OP_ANDI, OP_ORI:      classify = CLS_IMM;
      OP_LDI:                        classify = CLS_LDI;
      OP_LD:                         classify = CLS_LD;
      OP_ST:                         classify = CLS_ST;
      OP_BR:                         classify = CLS_BR;
      OP_HALT:                       classify = CLS_HALT;
      default:                       classify = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/step_counter.sv
// Control step register; holds its step while the memory wait is stalled.
module step_counter
  import cpu_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   stall,
  input  state_e next_state,
  output state_e state
);

  always_ff @(posedge clock) begin
    if (reset)
      state <= ST_IDLE;
    else if (!stall)
      state <= next_state;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control step generator: fetch/execute sequencing and datapath
// strobes as a Moore decode of the current step.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [4:0] ADD_OP = DEFAULT_ADD_OP
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       mem_ready,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       Zin,
  output logic       Zlowout,
  output logic       PCin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Cout,
  output logic       CONin,
  output logic       Read,
  output logic       Write,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic [4:0] alu_op,
  output logic       run
);

  state_e    state;
  state_e    next_state;
  logic      stall;
  op_class_e cls;

  assign cls = classify(opcode);

  step_counter u_step_counter (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .next_state (next_state),
    .state      (state)
  );

  always_comb begin
    next_state = state;
    stall   = 1'b0;
    PCout   = 1'b0; MARin  = 1'b0; IncPC = 1'b0; Zin   = 1'b0;
    Zlowout = 1'b0; PCin   = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin    = 1'b0; Yin    = 1'b0; Cout  = 1'b0; CONin = 1'b0;
    Read    = 1'b0; Write  = 1'b0;
    Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0;
    Rin     = 1'b0; Rout   = 1'b0; BAout = 1'b0;
    alu_op  = '0;
    run     = 1'b1;

    case (state)
      ST_IDLE: next_state = ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        next_state = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        stall = !mem_ready;
        next_state = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = ST_T3;
      end
      ST_T3: begin
        next_state = ST_T4;
        case (cls)
          CLS_REG, CLS_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CLS_HALT: next_state = ST_HALT;
          default: next_state = ST_T0;
        endcase
      end
      ST_T4: begin
        next_state = ST_T5;
        case (cls)
          CLS_REG: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          CLS_IMM: begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          CLS_LDI, CLS_LD, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
          CLS_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: next_state = ST_T0;
        endcase
      end
      ST_T5: begin
        next_state = ST_T6;
        case (cls)
          CLS_REG, CLS_IMM, CLS_LDI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state = ST_T0;
          end
          CLS_LD, CLS_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          CLS_BR: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
          default: next_state = ST_T0;
        endcase
      end
      ST_T6: begin
        next_state = ST_T0;
        case (cls)
          CLS_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            stall = !mem_ready;
            next_state = ST_T7;
          end
          CLS_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            next_state = ST_T7;
          end
          CLS_BR: begin Zlowout = con_ff; PCin = con_ff; end
          default: ;
        endcase
      end
      ST_T7: begin
        next_state = ST_T0;
        case (cls)
          CLS_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_ST: begin Write = 1'b1; stall = !mem_ready; end
          default: ;
        endcase
      end
      ST_HALT: run = 1'b0;
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control step generator for the mini CPU datapath. Consumes the 5-bit opcode produced by the register select/encode stage, the branch condition flag and the memory ready handshake. Walks each instruction through fetch and execute control steps, and drives the datapath strobes. These include the Gra/Grb/Grc/Rin/Rout/BAout selects that the select/encode stage turns into per-register enables. It is the initiator of that interface; the select/encode stage responds to it.

## Interface
Parameters:
- `ADD_OP`, 5'b00011: ALU code issued for address and branch-target arithmetic.

Ports:
- `clock`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `opcode`  in  5: IR[31:27] from the select/encode stage, valid from the cycle after `IRin`.
- `con_ff`  in  1: registered branch condition.
- `mem_ready`  in  1: memory has completed the current `Read`/`Write`.
- `PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRin, MDRout, IRin, Yin, Cout, CONin, Read, Write`  out  1 each: datapath strobes.
- `Gra, Grb, Grc, Rin, Rout, BAout`  out  1 each: register field select and direction, to the select/encode stage.
- `alu_op`  out  5: ALU operation code.
- `run`  out  1: high while executing; low after halt.

## Operation
- Opcodes live in a shared package:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - addi 01100, andi 01101, ori 01110
  - br 10010, nop 11010, halt 11011
  - Any other opcode executes as nop.
- States: IDLE, T0–T7, HALT. Outputs are a Moore function of state only. `alu_op` is 0 and every strobe is low unless listed for that state.
- IDLE: no strobes, `run`=1; next state T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 (strobes held) until `mem_ready`=1.
  - T2: MDRout, IRin.
- Register ALU ops (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, `alu_op`=opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- Immediate ALU ops (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, `alu_op`=opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- ldi: T3 Grb, BAout, Yin; T4 Cout, Zin, `alu_op`=ADD_OP; T5 Zlowout, Gra, Rin. Then T0.
- ld:
  - T3–T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold until `mem_ready`.
  - T7: MDRout, Gra, Rin. Then T0.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; hold until `mem_ready`. Then T0.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, `alu_op`=ADD_OP.
  - T6: if `con_ff`=1, Zlowout and PCin; otherwise no strobes. Then T0.
- nop/unknown: T3 with no strobes, then T0.
- halt: T3 → HALT. HALT has no strobes and `run`=0, and is left only by reset.
- At most one of Gra/Grb/Grc is high in any state.
- Rin and Rout are never high together.
- Read and Write are never high together.

## Timing
- Reset is checked before all other transitions. While `reset`=1 the state becomes IDLE on the next edge, even mid-instruction or in a wait state.
- Reset values (IDLE): all strobes 0, `alu_op`=0, `run`=1.
- Zero-wait latencies, measured T0 to next T0, exclusive:
  - register/immediate ALU and ldi: 6 cycles.
  - br: 7 cycles.
  - ld and st: 8 cycles.
  - nop: 4 cycles.
- Each cycle `mem_ready` is low in T1, T6(ld) or T7(st) adds one cycle, with strobes held stable.
- `mem_ready` is sampled only in wait states and ignored elsewhere.
- `opcode` is sampled in T3 and later. Its value in T0–T2 is don't-care.

## Structure
- Package `cpu_pkg`: opcode constants, the `ADD_OP` default, and the state enum.
- Sub-module `step_counter`: holds the state register, with synchronous reset and a stall input for the memory wait.
- Top-level: next-state and output decode as a single combinational block.

## Test plan
- Reset then add (00011), `mem_ready` tied 1:
  - T0 PCout/MARin/IncPC/Zin.
  - T4 Grc/Rout/Zin with `alu_op`=00011.
  - T5 Gra/Rin.
  - Next fetch 6 cycles after T0.
- ld with `mem_ready` low 2 cycles in both T1 and T6: Read/MDRin held 3 cycles each; T7 MDRout/Gra/Rin; total 12 cycles.
- st: T6 Gra/Rout/MDRin, then T7 Write held until `mem_ready`; no Rin at any step.
- br with `con_ff`=0 then `con_ff`=1: T6 strobes absent in the first case, Zlowout/PCin present in the second.
- halt (11011): `run` falls in HALT and no strobes follow for 20 cycles. Reset returns to IDLE with `run`=1, then T0.
- Reset asserted during ld T6 wait: IDLE on the next edge, all strobes 0; fetch resumes from T0.
